csr_issue_queue: RTL
====================

Name: csr_issue_queue

Overview:
- In-order issue buffer for CSR, mret and vector-config (vsetvli/vsetvl/vsetivli) micro-ops.
- Sits between dispatch and the CSR execution unit.
- Captures operands through writeback wakeup.
- Issues the head entry only when it is the oldest in-flight instruction and its operands are ready.
- Keeps at most one CSR-class op in flight until that op retires.

Parameters:
- DEPTH, 4, number of queue entries (power of two, ≥2).
- TAG_W, 6, physical register tag width.
- TICKET_W, 4, ROB ticket width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  dispatch offers an entry
- in_ready  output  1  queue can accept
- in_uop  input  5  microoperation (11000–11110 CSR/mret, 10000–10010 vcfg)
- in_ticket  input  TICKET_W  ROB ticket
- in_dest  input  TAG_W  destination tag
- in_csr_addr  input  12  CSR address / vtype immediate
- in_csr_imm  input  5  zimm
- in_src1_tag, in_src2_tag  input  TAG_W  source tags
- in_src1_rdy, in_src2_rdy  input  1  source already available
- in_data1, in_data2  input  32  source values (valid when rdy)
- wb_valid  input  1  writeback broadcast
- wb_tag  input  TAG_W  writeback tag
- wb_data  input  32  writeback value
- rob_head_ticket  input  TICKET_W  ticket of oldest ROB entry
- retire_valid  input  1  ROB retires an instruction
- retire_ticket  input  TICKET_W  retiring ticket
- flush  input  1  pipeline flush
- issue_valid  output  1  registered issue to CSR unit
- issue_uop, issue_ticket, issue_dest, issue_csr_addr, issue_csr_imm, issue_data1, issue_data2  output  as inputs  issued fields

Behaviour:
- Reset (rst_n low, asynchronous):
  - all entries invalid; head, tail and count = 0; FSM = READY.
  - issue_valid = 0; all issue_* fields = 0; in_ready = 1.
- Storage: circular FIFO with head/tail pointers that wrap at DEPTH and a count of width clog2(DEPTH)+1.
- in_ready = (count != DEPTH) and not flush. It is combinational and gives no credit for a same-cycle pop. Enqueue occurs when in_valid & in_ready, written at the tail at the clock edge.
- Enqueue bypass: if wb_valid and wb_tag == in_srcN_tag while in_srcN_rdy = 0, the entry is stored with rdy = 1 and data = wb_data.
- Wakeup: every valid entry with srcN not ready and tag == wb_tag while wb_valid sets rdy and captures wb_data at the edge.
- Issue condition, evaluated combinationally on the head entry:
  - head valid, src1 rdy and src2 rdy;
  - head ticket == rob_head_ticket;
  - FSM in READY;
  - flush = 0.
- On issue:
  - the head is popped and issue_* registered from the head entry; issue_valid = 1 for exactly one cycle.
  - FSM → WAIT_RETIRE; inflight_ticket is latched.
- When the issue condition is false, issue_valid = 0 next cycle and issue_* hold their last values.
- FSM:
  - READY → WAIT_RETIRE on issue.
  - WAIT_RETIRE → READY when retire_valid & retire_ticket == inflight_ticket, or on flush.
  - A retire match and a new issue cannot occur in the same cycle, because issue requires READY. The earliest next issue is the cycle after the return to READY.
- Latency: enqueue accepted in cycle t → earliest issue_valid high in cycle t+2, when operands are ready and the entry is the ROB head at t+1.
- Flush:
  - all entries invalid; head = tail = count = 0.
  - issue_valid = 0 next cycle; FSM → READY.
  - Flush dominates enqueue, wakeup, issue and retire in the same cycle.
- Simultaneous enqueue and pop with 0 < count < DEPTH: count unchanged, both take effect.
- Empty: no issue, and FSM behaviour is unchanged.
- Full: in_ready = 0 even if a pop occurs that cycle.
- Ticket compare is plain equality of TICKET_W bits; wrap-around is handled by the ROB.
- Operand requirements by micro-op:
  - Micro-ops that don't use a source are dispatched with that srcN_rdy = 1 (csrrwi/si/ci, mret, vsetivli: both; vsetvli: src2).
  - The queue itself does not decode uop for readiness.

Test Plan:
- Reset mid-operation with 3 entries queued and FSM in WAIT_RETIRE → immediately issue_valid = 0, in_ready = 1; after release, no issue until a new enqueue.
- Enqueue csrrw (uop 11000, ticket 5, src1 not ready, tag 12) with rob_head_ticket = 5; wb_valid, tag 12, data 0xDEADBEEF two cycles later → issue_valid one cycle later with issue_data1 = 0xDEADBEEF, issue_ticket = 5.
- Enqueue with in_src1_tag = 7 in the same cycle as wb_valid, tag 7, data 0x55 → entry issues at t+2 with data1 = 0x55.
- Two ready entries, tickets 2 and 3; rob_head_ticket steps 2 → 3 → ticket 2 issues; ticket 3 does not issue until retire_valid with ticket 2; it then issues 1 cycle after FSM returns to READY.
- Fill 4 entries → in_ready = 0; an issue pops one → in_ready = 1 next cycle; the tail wraps to index 0 on the next enqueue.
- Flush asserted together with in_valid and an issuable head → no issue_valid, count = 0, enqueue dropped, FSM = READY.

Source files
------------

// File: rtl/csr_issue_queue_if.sv
// csr_issue_queue_if: dispatch, writeback, ROB and issue signals of the CSR issue queue
//   master: dispatch/ROB/writeback side, drives requests and observes in_ready and issue_*
//   slave:  the queue, accepts requests and drives in_ready and issue_*
interface csr_issue_queue_if #(
    parameter int TAG_W    = 6,
    parameter int TICKET_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [4:0]          in_uop;
    logic [TICKET_W-1:0] in_ticket;
    logic [TAG_W-1:0]    in_dest;
    logic [11:0]         in_csr_addr;
    logic [4:0]          in_csr_imm;
    logic [TAG_W-1:0]    in_src1_tag;
    logic [TAG_W-1:0]    in_src2_tag;
    logic                in_src1_rdy;
    logic                in_src2_rdy;
    logic [31:0]         in_data1;
    logic [31:0]         in_data2;
    logic                wb_valid;
    logic [TAG_W-1:0]    wb_tag;
    logic [31:0]         wb_data;
    logic [TICKET_W-1:0] rob_head_ticket;
    logic                retire_valid;
    logic [TICKET_W-1:0] retire_ticket;
    logic                flush;
    logic                issue_valid;
    logic [4:0]          issue_uop;
    logic [TICKET_W-1:0] issue_ticket;
    logic [TAG_W-1:0]    issue_dest;
    logic [11:0]         issue_csr_addr;
    logic [4:0]          issue_csr_imm;
    logic [31:0]         issue_data1;
    logic [31:0]         issue_data2;

    modport master (
        output in_valid, in_uop, in_ticket, in_dest, in_csr_addr, in_csr_imm,
               in_src1_tag, in_src2_tag, in_src1_rdy, in_src2_rdy, in_data1, in_data2,
               wb_valid, wb_tag, wb_data, rob_head_ticket, retire_valid, retire_ticket, flush,
        input  in_ready, issue_valid, issue_uop, issue_ticket, issue_dest,
               issue_csr_addr, issue_csr_imm, issue_data1, issue_data2
    );

    modport slave (
        input  in_valid, in_uop, in_ticket, in_dest, in_csr_addr, in_csr_imm,
               in_src1_tag, in_src2_tag, in_src1_rdy, in_src2_rdy, in_data1, in_data2,
               wb_valid, wb_tag, wb_data, rob_head_ticket, retire_valid, retire_ticket, flush,
        output in_ready, issue_valid, issue_uop, issue_ticket, issue_dest,
               issue_csr_addr, issue_csr_imm, issue_data1, issue_data2
    );
endinterface

// File: rtl/csr_issue_queue.sv
// csr_issue_queue: in-order issue buffer for CSR/mret/vcfg micro-ops, one op in flight until retire
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of csr_issue_queue_if (dispatch in_*, wb_*, rob/retire, flush, issue_*)
module csr_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 6,
    parameter int TICKET_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    csr_issue_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {READY, WAIT_RETIRE} state_t;

    logic [DEPTH-1:0]    e_v, e_r1, e_r2;
    logic [4:0]          e_uop  [DEPTH];
    logic [TICKET_W-1:0] e_tk   [DEPTH];
    logic [TAG_W-1:0]    e_dest [DEPTH];
    logic [11:0]         e_addr [DEPTH];
    logic [4:0]          e_imm  [DEPTH];
    logic [TAG_W-1:0]    e_t1   [DEPTH];
    logic [TAG_W-1:0]    e_t2   [DEPTH];
    logic [31:0]         e_d1   [DEPTH];
    logic [31:0]         e_d2   [DEPTH];
    logic [PW-1:0]       head, tail;
    logic [CW-1:0]       count;
    logic [TICKET_W-1:0] inflight;
    state_t              state;
    logic                push, pop, byp1, byp2;

    // No credit for a same-cycle pop: a full queue stays not-ready even while issuing.
    assign bus.in_ready = (count != CW'(DEPTH)) && !bus.flush;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = e_v[head] && e_r1[head] && e_r2[head] && (e_tk[head] == bus.rob_head_ticket)
                  && (state == READY) && !bus.flush;
    // A writeback landing in the dispatch cycle is captured directly into the new entry.
    assign byp1 = bus.wb_valid && (bus.wb_tag == bus.in_src1_tag);
    assign byp2 = bus.wb_valid && (bus.wb_tag == bus.in_src2_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            state    <= READY;
            inflight <= '0;
            e_v      <= '0;
            e_r1     <= '0;
            e_r2     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_uop[i]  <= '0;
                e_tk[i]   <= '0;
                e_dest[i] <= '0;
                e_addr[i] <= '0;
                e_imm[i]  <= '0;
                e_t1[i]   <= '0;
                e_t2[i]   <= '0;
                e_d1[i]   <= '0;
                e_d2[i]   <= '0;
            end
            bus.issue_valid    <= 1'b0;
            bus.issue_uop      <= '0;
            bus.issue_ticket   <= '0;
            bus.issue_dest     <= '0;
            bus.issue_csr_addr <= '0;
            bus.issue_csr_imm  <= '0;
            bus.issue_data1    <= '0;
            bus.issue_data2    <= '0;
        end else if (bus.flush) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            e_v             <= '0;
            state           <= READY;
            bus.issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_v[i] && bus.wb_valid && !e_r1[i] && (e_t1[i] == bus.wb_tag)) begin
                    e_r1[i] <= 1'b1;
                    e_d1[i] <= bus.wb_data;
                end
                if (e_v[i] && bus.wb_valid && !e_r2[i] && (e_t2[i] == bus.wb_tag)) begin
                    e_r2[i] <= 1'b1;
                    e_d2[i] <= bus.wb_data;
                end
            end
            if (push) begin
                e_v[tail]    <= 1'b1;
                e_uop[tail]  <= bus.in_uop;
                e_tk[tail]   <= bus.in_ticket;
                e_dest[tail] <= bus.in_dest;
                e_addr[tail] <= bus.in_csr_addr;
                e_imm[tail]  <= bus.in_csr_imm;
                e_t1[tail]   <= bus.in_src1_tag;
                e_t2[tail]   <= bus.in_src2_tag;
                e_r1[tail]   <= bus.in_src1_rdy || byp1;
                e_r2[tail]   <= bus.in_src2_rdy || byp2;
                e_d1[tail]   <= bus.in_src1_rdy ? bus.in_data1 : bus.wb_data;
                e_d2[tail]   <= bus.in_src2_rdy ? bus.in_data2 : bus.wb_data;
                tail         <= tail + PW'(1);
            end
            if (pop) begin
                e_v[head]          <= 1'b0;
                head               <= head + PW'(1);
                bus.issue_uop      <= e_uop[head];
                bus.issue_ticket   <= e_tk[head];
                bus.issue_dest     <= e_dest[head];
                bus.issue_csr_addr <= e_addr[head];
                bus.issue_csr_imm  <= e_imm[head];
                bus.issue_data1    <= e_d1[head];
                bus.issue_data2    <= e_d2[head];
            end
            bus.issue_valid <= pop;
            count           <= count + CW'(push) - CW'(pop);
            inflight        <= pop ? e_tk[head] : inflight;
            state           <= (state == READY) ? (pop ? WAIT_RETIRE : READY)
                             : ((bus.retire_valid && bus.retire_ticket == inflight) ? READY : WAIT_RETIRE);
        end
    end
endmodule
